// File: rtl/cv32e40p_obi_sram_bridge.sv
// rtl/cv32e40p_obi_sram_bridge.sv - OBI slave to single-port SRAM bridge
// Grants with optional wait states, bounds outstanding requests, returns responses in grant order.
module cv32e40p_obi_sram_bridge #(
  parameter int          ADDR_WIDTH      = 14,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          WAIT_STATES     = 0,
  parameter int          RESP_LATENCY    = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [2:0]              outstanding_q;
  logic                    room;
  logic                    gnt;
  logic                    in_range;
  logic [31:0]             offset;
  logic [RESP_LATENCY-1:0] v_q, err_q, rd_q;
  logic [31:0]             cap;
  logic [31:0]             rdata_q;

  // 33-bit compare so the window size never wraps to zero
  assign offset   = addr_i - BASE_ADDR;
  assign in_range = (addr_i >= BASE_ADDR) && ({1'b0, offset} < (33'd4 << ADDR_WIDTH));

  assign rvalid_o = v_q[RESP_LATENCY-1] && !rst_i;
  assign room     = (outstanding_q < 3'(MAX_OUTSTANDING)) || rvalid_o;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gnt        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (WAIT_STATES == 0) begin
            gnt = room;
          end else begin
            wait_cnt_d = 4'(WAIT_STATES - 1);
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req_i) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else if (room) begin
          gnt     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else if (gnt && !rvalid_o) begin
      outstanding_q <= outstanding_q + 3'd1;
    end else if (!gnt && rvalid_o) begin
      outstanding_q <= outstanding_q - 3'd1;
    end
  end

  // Per-grant response flags travel down a RESP_LATENCY deep shift register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q   <= '0;
      err_q <= '0;
      rd_q  <= '0;
    end else begin
      v_q[0]   <= gnt;
      err_q[0] <= gnt && !in_range;
      rd_q[0]  <= gnt && in_range && !we_i;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        v_q[i]   <= v_q[i-1];
        err_q[i] <= err_q[i-1];
        rd_q[i]  <= rd_q[i-1];
      end
    end
  end

  assign cap = (v_q[0] && rd_q[0]) ? mem_rdata_i : '0;

  generate
    if (RESP_LATENCY == 1) begin : g_lat1
      assign rdata_q = cap;
    end else begin : g_latn
      logic [31:0] dq [RESP_LATENCY-1];
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < RESP_LATENCY-1; i++) dq[i] <= '0;
        end else begin
          dq[0] <= cap;
          for (int i = 1; i < RESP_LATENCY-1; i++) dq[i] <= dq[i-1];
        end
      end
      assign rdata_q = dq[RESP_LATENCY-2];
    end
  endgenerate

  assign gnt_o       = gnt && !rst_i;
  assign rdata_o     = rvalid_o ? rdata_q : '0;
  assign err_o       = rvalid_o && err_q[RESP_LATENCY-1];
  assign mem_req_o   = gnt_o && in_range;
  assign mem_we_o    = mem_req_o && we_i;
  assign mem_be_o    = mem_req_o ? be_i : '0;
  assign mem_addr_o  = mem_req_o ? offset[ADDR_WIDTH+1:2] : '0;
  assign mem_wdata_o = mem_req_o ? wdata_i : '0;

endmodule

// File: tb/tb_cv32e40p_obi_sram_bridge.sv
// tb/tb_cv32e40p_obi_sram_bridge.sv - directed and randomized checks of the OBI SRAM bridge
// Three instances cover default timing, wait states with a small window, and long latency throttling.
module tb_cv32e40p_obi_sram_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        a_req = 1'b0, a_we = 1'b0, a_gnt, a_rvalid, a_err, a_mreq, a_mwe;
  logic [3:0]  a_be = 4'h0, a_mbe;
  logic [31:0] a_addr = '0, a_wdata = '0, a_rdata, a_mwdata, a_mrdata;
  logic [13:0] a_maddr;

  logic        b_req = 1'b0, b_we = 1'b0, b_gnt, b_rvalid, b_err, b_mreq, b_mwe;
  logic [3:0]  b_be = 4'h0, b_mbe;
  logic [31:0] b_addr = '0, b_wdata = '0, b_rdata, b_mwdata, b_mrdata;
  logic [3:0]  b_maddr;

  logic        c_req = 1'b0, c_we = 1'b0, c_gnt, c_rvalid, c_err, c_mreq, c_mwe;
  logic [3:0]  c_be = 4'h0, c_mbe;
  logic [31:0] c_addr = '0, c_wdata = '0, c_rdata, c_mwdata, c_mrdata;
  logic [13:0] c_maddr;

  cv32e40p_obi_sram_bridge u_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr), .we_i(a_we),
    .be_i(a_be), .wdata_i(a_wdata), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err),
    .mem_req_o(a_mreq), .mem_we_o(a_mwe), .mem_be_o(a_mbe), .mem_addr_o(a_maddr),
    .mem_wdata_o(a_mwdata), .mem_rdata_i(a_mrdata)
  );

  cv32e40p_obi_sram_bridge #(
    .ADDR_WIDTH(4), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .gnt_o(b_gnt), .addr_i(b_addr), .we_i(b_we),
    .be_i(b_be), .wdata_i(b_wdata), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err),
    .mem_req_o(b_mreq), .mem_we_o(b_mwe), .mem_be_o(b_mbe), .mem_addr_o(b_maddr),
    .mem_wdata_o(b_mwdata), .mem_rdata_i(b_mrdata)
  );

  cv32e40p_obi_sram_bridge #(
    .WAIT_STATES(0), .RESP_LATENCY(4), .MAX_OUTSTANDING(2)
  ) u_c (
    .clk_i(clk), .rst_i(rst), .req_i(c_req), .gnt_o(c_gnt), .addr_i(c_addr), .we_i(c_we),
    .be_i(c_be), .wdata_i(c_wdata), .rvalid_o(c_rvalid), .rdata_o(c_rdata), .err_o(c_err),
    .mem_req_o(c_mreq), .mem_we_o(c_mwe), .mem_be_o(c_mbe), .mem_addr_o(c_maddr),
    .mem_wdata_o(c_mwdata), .mem_rdata_i(c_mrdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h1357_9BDF ^ (32'(i) * 32'h0104_1041);
  endfunction

  // SRAM behind A: 64 words, upper address bits alias
  logic [31:0] sram [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
    end else if (a_mreq) begin
      a_mrdata <= sram[a_maddr[5:0]];
      for (int k = 0; k < 4; k++)
        if (a_mwe && a_mbe[k]) sram[a_maddr[5:0]][8*k +: 8] <= a_mwdata[8*k +: 8];
    end
  end

  always @(posedge clk) if (b_mreq) b_mrdata <= 32'hB0B0_0000 | 32'(b_maddr);
  always @(posedge clk) if (c_mreq) c_mrdata <= 32'hC0C0_0000 | 32'(c_maddr);

  logic [31:0] ref_mem [64];
  logic        pend_v = 1'b0, pend_err = 1'b0;
  logic [31:0] pend_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle on A: every request is granted at once and answered the next cycle
  task automatic a_cycle(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
    logic in_r;
    @(negedge clk);
    a_req = req; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
    #1;
    in_r = addr < 32'h0001_0000;
    chk("a_gnt", 32'(a_gnt), 32'(req));
    chk("a_mem_req", 32'(a_mreq), 32'(req && in_r));
    if (req && in_r) begin
      chk("a_mem_addr", 32'(a_maddr), 32'(addr[15:2]));
      chk("a_mem_we", 32'(a_mwe), 32'(we));
      chk("a_mem_be", 32'(a_mbe), 32'(be));
      chk("a_mem_wdata", a_mwdata, wd);
    end
    chk("a_rvalid", 32'(a_rvalid), 32'(pend_v));
    chk("a_rdata", a_rdata, pend_data);
    chk("a_err", 32'(a_err), 32'(pend_v && pend_err));
    pend_v    = req;
    pend_err  = req && !in_r;
    pend_data = '0;
    if (req && in_r && !we) pend_data = ref_mem[addr[7:2]];
    if (req && in_r && we)
      for (int k = 0; k < 4; k++) if (be[k]) ref_mem[addr[7:2]][8*k +: 8] = wd[8*k +: 8];
  endtask

  // One read on B: three wait cycles, grant on the fourth, response one cycle later
  task automatic b_txn(input logic [31:0] addr, input logic in_r, input logic [3:0] exp_maddr,
                       input logic [31:0] exp_rdata);
    @(negedge clk);
    b_req = 1'b1; b_addr = addr; b_we = 1'b0; b_be = 4'hF; b_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("b_gnt", 32'(b_gnt), 32'(k == 3));
      chk("b_rvalid_early", 32'(b_rvalid), 32'd0);
      if (k == 3) begin
        chk("b_mem_req", 32'(b_mreq), 32'(in_r));
        if (in_r) chk("b_mem_addr", 32'(b_maddr), 32'(exp_maddr));
      end
    end
    @(negedge clk);
    b_req = 1'b0;
    #1;
    chk("b_rvalid", 32'(b_rvalid), 32'd1);
    chk("b_err", 32'(b_err), 32'(!in_r));
    chk("b_rdata", b_rdata, exp_rdata);
  endtask

  int          due[$];
  logic [31:0] exp_data_q[$];
  logic        exp_err_q[$];

  initial begin
    logic [13:0] gmask, rvmask;
    int          r;
    logic        req, we, in_r, retiring, exp_g;
    logic [31:0] addr;

    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    // Reset with requests pending: everything held at zero
    a_req = 1'b1; a_addr = 32'h10; b_req = 1'b1; b_addr = 32'h1000; c_req = 1'b1; c_addr = 32'h40;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk); #1;
      chk("rst_a_gnt", 32'(a_gnt), 32'd0);
      chk("rst_a_mem_req", 32'(a_mreq), 32'd0);
      chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
      chk("rst_a_rdata", a_rdata, 32'd0);
      chk("rst_b_gnt", 32'(b_gnt), 32'd0);
      chk("rst_c_gnt", 32'(c_gnt), 32'd0);
      chk("rst_c_mem_addr", 32'(c_maddr), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0; c_req = 1'b0;

    // A directed: first cycle after reset, then the documented read and write cases
    a_cycle(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    a_cycle(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    a_cycle(1'b1, 1'b1, 4'b0011, 32'h8, 32'h1234_5678);
    a_cycle(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
    a_cycle(1'b1, 1'b0, 4'hF, 32'h0000_FFFC, 32'h0);
    a_cycle(1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
    a_cycle(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFC, 32'h5555_AAAA);
    a_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // A randomized against the reference memory
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2)
        a_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      else if (r < 3)
        a_cycle(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 32'h0001_0000 + ($urandom & 32'h00FF_FFFC), $urandom);
      else
        a_cycle(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), {16'h0, 14'($urandom), 2'b00}, $urandom);
    end
    a_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // B: window 0x1000..0x103F, three wait states
    b_txn(32'h0000_1040, 1'b0, 4'd0, 32'h0);
    b_txn(32'h0000_0FFC, 1'b0, 4'd0, 32'h0);
    b_txn(32'h0000_103C, 1'b1, 4'd15, 32'hB0B0_000F);
    @(negedge clk);
    b_req = 1'b1; b_addr = 32'h1000;
    @(negedge clk);
    b_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("b_drop_gnt", 32'(b_gnt), 32'd0);
      chk("b_drop_rvalid", 32'(b_rvalid), 32'd0);
    end
    b_txn(32'h0000_1000, 1'b1, 4'd0, 32'hB0B0_0000);

    // C directed: request held for ten cycles against latency 4, two outstanding
    gmask  = 14'b00_0011_0011_0011;
    rvmask = 14'b11_0011_0011_0000;
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_be = 4'hF; c_addr = 32'h40;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 10) c_req = 1'b0;
      #1;
      chk("c_thr_gnt", 32'(c_gnt), 32'(gmask[k]));
      chk("c_thr_rvalid", 32'(c_rvalid), 32'(rvmask[k]));
      chk("c_thr_rdata", c_rdata, rvmask[k] ? 32'hC0C0_0010 : 32'h0);
    end

    // C randomized: responses due RESP_LATENCY after grant, granted while fewer than two are pending
    for (int now = 0; now < 206; now++) begin
      @(negedge clk);
      req  = (now < 200) && ($urandom_range(0, 3) != 0);
      we   = 1'($urandom_range(0, 3) == 0);
      addr = ($urandom_range(0, 7) == 0) ? 32'h0002_0000 + ($urandom & 32'h0000_FFFC)
                                          : {16'h0, 14'($urandom), 2'b00};
      c_req = req; c_we = we; c_addr = addr; c_be = 4'($urandom); c_wdata = $urandom;
      #1;
      in_r     = addr < 32'h0001_0000;
      retiring = (due.size() > 0) && (due[0] == now);
      exp_g    = req && ((due.size() < 2) || retiring);
      chk("c_gnt", 32'(c_gnt), 32'(exp_g));
      chk("c_mem_req", 32'(c_mreq), 32'(exp_g && in_r));
      chk("c_rvalid", 32'(c_rvalid), 32'(retiring));
      if (retiring) begin
        chk("c_rdata", c_rdata, exp_data_q[0]);
        chk("c_err", 32'(c_err), 32'(exp_err_q[0]));
        void'(due.pop_front());
        void'(exp_data_q.pop_front());
        void'(exp_err_q.pop_front());
      end else begin
        chk("c_rdata_idle", c_rdata, 32'h0);
        chk("c_err_idle", 32'(c_err), 32'd0);
      end
      if (exp_g) begin
        due.push_back(now + 4);
        exp_data_q.push_back((in_r && !we) ? (32'hC0C0_0000 | {18'h0, addr[15:2]}) : 32'h0);
        exp_err_q.push_back(!in_r);
      end
    end
    chk("c_drained", 32'(due.size()), 32'd0);

    // C: reset one cycle after a grant discards that response
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
    #1;
    chk("c_rst_pre_gnt", 32'(c_gnt), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("c_rst_gnt", 32'(c_gnt), 32'd0);
    chk("c_rst_mem_req", 32'(c_mreq), 32'd0);
    chk("c_rst_rvalid", 32'(c_rvalid), 32'd0);
    chk("c_rst_rdata", c_rdata, 32'd0);
    chk("c_rst_err", 32'(c_err), 32'd0);
    @(negedge clk);
    rst = 1'b0; c_req = 1'b0;
    for (int k = 2; k < 8; k++) begin
      if (k > 2) @(negedge clk);
      #1;
      chk("c_rst_no_rvalid", 32'(c_rvalid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
